// File: rtl/hitsound_mixer.sv
// Sample-rate mixer: sums background music with four ROM-backed hit-sound voices,
// saturates, and emits one offset-binary sample per sample tick.
module hitsound_mixer #(
  parameter int SFX_LEN = 512,
  parameter int ADDR_W  = 11
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sample_tick,
  input  logic [7:0]        music_sample,
  input  logic [3:0]        hit,
  output logic [ADDR_W-1:0] sfx_addr,
  input  logic [7:0]        sfx_data,
  output logic [7:0]        mix_out,
  output logic              mix_valid,
  output logic [3:0]        active
);

  localparam int POS_W = $clog2(SFX_LEN);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_SAT
  } state_t;

  state_t            state;
  logic [1:0]        voice;
  logic [POS_W-1:0]  pos [4];
  logic signed [9:0] acc;
  logic [7:0]        music_q;

  logic [1:0]        next_voice;
  logic [7:0]        rom_centered;
  logic signed [9:0] voice_term;
  logic signed [9:0] music_term;
  logic signed [9:0] sum;
  logic [7:0]        clamped;

  // Flipping the MSB turns offset binary into two's complement; the voice term
  // is then halved with sign extension so four voices fit beside the music.
  always_comb begin
    next_voice   = voice + 2'd1;
    rom_centered = sfx_data ^ 8'h80;
    voice_term   = {{3{rom_centered[7]}}, rom_centered[7:1]};
    music_term   = {{2{music_q[7]}}, music_q};
    sum          = music_term + acc;
    clamped      = sum[7:0] ^ 8'h80;
    if (sum > 10'sd127) begin
      clamped = 8'hff;
    end else if (sum < -10'sd128) begin
      clamped = 8'h00;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= S_IDLE;
      voice     <= 2'd0;
      acc       <= '0;
      music_q   <= 8'h00;
      sfx_addr  <= '0;
      mix_out   <= 8'd128;
      mix_valid <= 1'b0;
      active    <= 4'b0000;
      for (int i = 0; i < 4; i++) begin
        pos[i] <= '0;
      end
    end else begin
      mix_valid <= 1'b0;

      // Voice bookkeeping: a hit restarts the lane and wins over the DATA-cycle advance.
      for (int i = 0; i < 4; i++) begin
        if (hit[i]) begin
          active[i] <= 1'b1;
          pos[i]    <= '0;
        end else if (state == S_DATA && voice == 2'(i) && active[i]) begin
          if (pos[i] == POS_W'(SFX_LEN - 1)) begin
            active[i] <= 1'b0;
          end else begin
            pos[i] <= pos[i] + 1'b1;
          end
        end
      end

      case (state)
        S_IDLE: begin
          if (sample_tick) begin
            music_q  <= music_sample ^ 8'h80;
            acc      <= '0;
            voice    <= 2'd0;
            sfx_addr <= ADDR_W'({2'd0, pos[0]});
            state    <= S_ADDR;
          end
        end
        S_ADDR: begin
          state <= S_DATA;
        end
        S_DATA: begin
          if (active[voice]) begin
            acc <= acc + voice_term;
          end
          if (voice == 2'd3) begin
            state <= S_SAT;
          end else begin
            voice    <= next_voice;
            sfx_addr <= ADDR_W'({next_voice, pos[next_voice]});
            state    <= S_ADDR;
          end
        end
        S_SAT: begin
          mix_out   <= clamped;
          mix_valid <= 1'b1;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hitsound_mixer.sv
// Directed bench for hitsound_mixer with a short (4-sample) effect length so
// voice end-of-effect and retrigger are reachable in a few frames.
module tb_hitsound_mixer;

  localparam int LEN = 4;
  localparam int AW  = 4;

  logic          clk;
  logic          reset;
  logic          sample_tick;
  logic [7:0]    music_sample;
  logic [3:0]    hit;
  logic [AW-1:0] sfx_addr;
  logic [7:0]    sfx_data;
  logic [7:0]    mix_out;
  logic          mix_valid;
  logic [3:0]    active;

  logic [7:0]    rom [16];
  logic [7:0]    exp_q [$];
  int            checks = 0;
  int            errors = 0;

  hitsound_mixer #(.SFX_LEN(LEN), .ADDR_W(AW)) dut (
    .clk          (clk),
    .reset        (reset),
    .sample_tick  (sample_tick),
    .music_sample (music_sample),
    .hit          (hit),
    .sfx_addr     (sfx_addr),
    .sfx_data     (sfx_data),
    .mix_out      (mix_out),
    .mix_valid    (mix_valid),
    .active       (active)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous ROM, one cycle of latency
  always @(posedge clk) sfx_data <= rom[sfx_addr];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: every mix_valid strobe pops one expected sample.
  always @(negedge clk) begin
    if (mix_valid === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL mix_unexpected: got mix_valid with mix_out %0d, expected none at %0t",
                 mix_out, $time);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (mix_out !== e) begin
          errors++;
          $display("FAIL mix_out: got %0d expected %0d at %0t", mix_out, e, $time);
        end
      end
    end
  end

  // Driver tasks
  task automatic fill(input int base, input int n, input logic [7:0] v);
    for (int i = base; i < base + n; i++) rom[i] = v;
  endtask

  task automatic pulse_hit(input logic [3:0] h);
    @(negedge clk);
    hit = h;
    @(negedge clk);
    hit = 4'b0000;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check("idle_valid", 32'(mix_valid), 32'd0);
    end
  endtask

  // One tick at edge E0; k indexes the negedge after edge E(k).
  task automatic run_frame(input logic [7:0] m, input logic [7:0] exp, input int av,
                           input logic [AW-1:0] exp_addr, input bit extra_tick);
    exp_q.push_back(exp);
    @(negedge clk);
    sample_tick  = 1'b1;
    music_sample = m;
    @(negedge clk);
    sample_tick  = 1'b0;
    music_sample = ~m;
    for (int k = 0; k <= 10; k++) begin
      if (k > 0) @(negedge clk);
      if (av >= 0 && k == 2 * av) check("sfx_addr", 32'(sfx_addr), 32'(exp_addr));
      check("valid_timing", 32'(mix_valid), (k == 9) ? 32'd1 : 32'd0);
      sample_tick = (extra_tick && k == 3);
    end
    sample_tick = 1'b0;
  endtask

  initial begin
    reset        = 1'b0;
    sample_tick  = 1'b0;
    music_sample = 8'd128;
    hit          = 4'b0000;
    fill(0, 16, 8'd128);

    // Reset held with ticks and hits toggling
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      sample_tick = 1'($urandom_range(0, 1));
      hit         = 4'($urandom_range(0, 15));
    end
    @(negedge clk);
    check("rst_mix_out", 32'(mix_out), 32'd128);
    check("rst_valid", 32'(mix_valid), 32'd0);
    check("rst_active", 32'(active), 32'd0);
    check("rst_addr", 32'(sfx_addr), 32'd0);
    reset       = 1'b1;
    sample_tick = 1'b0;
    hit         = 4'b0000;
    idle(2);

    // Passthrough, with a second tick at E4 that must be ignored
    run_frame(8'd200, 8'd200, 2, 4'd8, 1'b1);
    idle(3);

    // Single voice on lane 1
    fill(4, 4, 8'd228);
    pulse_hit(4'b0010);
    check("active_single", 32'(active), 32'b0010);
    run_frame(8'd128, 8'd178, 1, 4'd4, 1'b0);
    run_frame(8'd128, 8'd178, 1, 4'd5, 1'b0);
    check("active_single2", 32'(active), 32'b0010);

    // Positive saturation
    fill(0, 16, 8'd255);
    pulse_hit(4'b1111);
    check("active_all", 32'(active), 32'b1111);
    run_frame(8'd255, 8'd255, 3, 4'd12, 1'b0);

    // Negative saturation
    fill(0, 16, 8'd0);
    run_frame(8'd0, 8'd0, 3, 4'd13, 1'b0);

    // Mixed in-range sum: -28 + 8 + 0 - 24 + 63 = 19 -> 147
    fill(0, 4, 8'h90);
    fill(4, 4, 8'd128);
    fill(8, 4, 8'h50);
    fill(12, 4, 8'd255);
    run_frame(8'd100, 8'd147, 2, 4'd10, 1'b0);
    check("active_before_end", 32'(active), 32'b1111);

    // Last sample of every voice, then silence
    fill(0, 16, 8'd255);
    run_frame(8'd128, 8'd255, 0, 4'd3, 1'b0);
    check("active_all_end", 32'(active), 32'b0000);
    run_frame(8'd128, 8'd128, 0, 4'd3, 1'b0);

    // Lane 0 plays four distinct samples and ends
    rom[0] = 8'h90; rom[1] = 8'ha0; rom[2] = 8'hb0; rom[3] = 8'hc0;
    pulse_hit(4'b0001);
    run_frame(8'd128, 8'd136, 0, 4'd0, 1'b0);
    run_frame(8'd128, 8'd144, 0, 4'd1, 1'b0);
    run_frame(8'd128, 8'd152, 0, 4'd2, 1'b0);
    check("active_lane0_3", 32'(active), 32'b0001);
    run_frame(8'd128, 8'd160, 0, 4'd3, 1'b0);
    check("active_lane0_end", 32'(active), 32'b0000);
    run_frame(8'd128, 8'd128, 0, 4'd3, 1'b0);

    // Retrigger after the second tick restarts at address 0
    pulse_hit(4'b0001);
    run_frame(8'd128, 8'd136, 0, 4'd0, 1'b0);
    run_frame(8'd128, 8'd144, 0, 4'd1, 1'b0);
    pulse_hit(4'b0001);
    run_frame(8'd128, 8'd136, 0, 4'd0, 1'b0);
    check("active_retrig", 32'(active), 32'b0001);

    // Reset at E4 aborts the frame
    @(negedge clk);
    sample_tick  = 1'b1;
    music_sample = 8'd30;
    @(negedge clk);
    sample_tick = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("midrst_active", 32'(active), 32'd0);
    check("midrst_mix_out", 32'(mix_out), 32'd128);
    check("midrst_valid", 32'(mix_valid), 32'd0);
    reset = 1'b1;
    idle(12);
    run_frame(8'd200, 8'd200, 0, 4'd0, 1'b0);

    idle(2);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
